// File: rtl/dm_pkg.sv
// Shared constants for the multi-port data memory: FSM encoding and default widths.
package dm_pkg;

  localparam int DM_DATA_W = 16;
  localparam int DM_ADDR_W = 8;
  localparam int DM_NUM_RD = 2;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

endpackage

// File: rtl/dm_bank.sv
// One simple-dual-port bank: 1 write port with half-word mask, 1 registered read port.
module dm_bank
  import dm_pkg::*;
#(
  parameter int DATA_WIDTH = DM_DATA_W,
  parameter int ADDR_WIDTH = DM_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [1:0]              wmask,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [2*DATA_WIDTH-1:0] wdata,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [2*DATA_WIDTH-1:0] q
);

  logic [2*DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Array kept reset-free so it maps onto block RAM; contents are cleared by the sweep.
  always_ff @(posedge clk) begin
    if (we) begin
      if (wmask[0]) mem[waddr][DATA_WIDTH-1:0]            <= wdata[DATA_WIDTH-1:0];
      if (wmask[1]) mem[waddr][2*DATA_WIDTH-1:DATA_WIDTH] <= wdata[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/dm_multiport.sv
// Replicated-bank memory with NUM_RD read ports, write-first bypass, clear-on-reset sweep.
module dm_multiport
  import dm_pkg::*;
#(
  parameter int DATA_WIDTH = DM_DATA_W,
  parameter int ADDR_WIDTH = DM_ADDR_W,
  parameter int NUM_RD     = DM_NUM_RD,
  parameter int OUT_REG    = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wren,
  input  logic [1:0]                     wmask,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic [2*DATA_WIDTH-1:0]        wdata,
  input  logic                           rden,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   raddr,
  output logic [NUM_RD*2*DATA_WIDTH-1:0] rdata,
  output logic                           rvalid,
  output logic                           init_busy
);

  localparam int W  = 2*DATA_WIDTH;
  localparam int RL = (OUT_REG != 0) ? 2 : 1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  ready, rd_acc, wr_acc;

  assign ready     = (state == ST_READY);
  assign init_busy = !ready;
  assign rd_acc    = rden && ready;
  assign wr_acc    = wren && ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else if (state == ST_INIT) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (&clr_cnt) state <= ST_READY;
    end
  end

  // Shared bank write port: the clear sweep owns it until READY.
  logic                  bwe;
  logic [1:0]            bmask;
  logic [ADDR_WIDTH-1:0] baddr;
  logic [W-1:0]          bdata;

  assign bwe   = !rst && (!ready || wren);
  assign bmask = ready ? wmask : 2'b11;
  assign baddr = ready ? waddr : clr_cnt;
  assign bdata = ready ? wdata : '0;

  logic [RL:0]   vld_pipe;
  logic [RL:1]   vld_q;

  assign vld_pipe = {vld_q, rd_acc};

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_pipe[RL-1:0];
  end

  assign rvalid = vld_pipe[RL];

  logic [NUM_RD-1:0]        hit, byp_hit;
  logic [1:0]               byp_mask;
  logic [W-1:0]             byp_data;
  logic [NUM_RD-1:0][W-1:0] q, d1;

  // Write data captured with the read so the merge lines up with the bank's output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_hit  <= '0;
      byp_mask <= '0;
      byp_data <= '0;
    end else if (rd_acc) begin
      byp_hit  <= hit;
      byp_mask <= wmask;
      byp_data <= wdata;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    dm_bank #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (bwe),
      .wmask (bmask),
      .waddr (baddr),
      .wdata (bdata),
      .re    (rd_acc),
      .raddr (raddr[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .q     (q[k])
    );

    assign hit[k] = wr_acc && (raddr[k*ADDR_WIDTH +: ADDR_WIDTH] == waddr);

    assign d1[k] = {(byp_hit[k] && byp_mask[1]) ? byp_data[W-1:DATA_WIDTH] : q[k][W-1:DATA_WIDTH],
                    (byp_hit[k] && byp_mask[0]) ? byp_data[DATA_WIDTH-1:0] : q[k][DATA_WIDTH-1:0]};
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [NUM_RD*W-1:0] rdata_q;
    always_ff @(posedge clk) begin
      if (rst)              rdata_q <= '0;
      else if (vld_pipe[1]) rdata_q <= d1;
    end
    assign rdata = rdata_q;
  end else begin : g_noreg
    assign rdata = d1;
  end

endmodule

// File: tb/tb_dm_multiport.sv
// Scoreboard bench for dm_multiport: directed reads queue expectations, a negedge monitor retires them.
module tb_dm_multiport;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 2;
  localparam int W  = 2*DW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wren = 1'b0, rden = 1'b0;
  logic [1:0]      wmask = '0;
  logic [AW-1:0]   waddr = '0;
  logic [W-1:0]    wdata = '0;
  logic [NR*AW-1:0] raddr = '0;
  logic [NR*W-1:0] rdata;
  logic            rvalid, init_busy;

  dm_multiport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .OUT_REG(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .wren      (wren),
    .wmask     (wmask),
    .waddr     (waddr),
    .wdata     (wdata),
    .rden      (rden),
    .raddr     (raddr),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             cyc;
    logic [NR*W-1:0] data;
  } exp_t;

  exp_t            sb[$];
  exp_t            me;
  int              checks = 0, errors = 0, ncyc = 0;
  logic            prev_rst = 1'b1;
  logic [NR*W-1:0] hold_exp = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: retires one expectation per rvalid, otherwise rdata must hold.
  always @(negedge clk) begin
    ncyc++;
    if (prev_rst) hold_exp = '0;
    if (rvalid) begin
      if (sb.size() == 0) chk("spurious_rvalid", 64'd1, 64'd0);
      else begin
        me = sb.pop_front();
        chk("rd_latency", 64'(ncyc), 64'(me.cyc));
        chk("rd_data", rdata, me.data);
        hold_exp = me.data;
      end
    end else begin
      chk("rdata_hold", rdata, hold_exp);
    end
    prev_rst = rst;
  end

  task automatic step();
    @(posedge clk); #1;
    wren = 1'b0; rden = 1'b0; wmask = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [1:0] m);
    wren = 1'b1; waddr = a; wdata = d; wmask = m;
  endtask

  // Issue at posedge+1: sampled on the next edge, rvalid seen three negedges on.
  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                    input logic [W-1:0] e0, input logic [W-1:0] e1);
    rden = 1'b1; raddr = {a1, a0};
    sb.push_back('{ncyc + 3, {e1, e0}});
  endtask

  task automatic count_busy(output int n, input bit poke);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!init_busy) break;
      n++;
      if (poke && i >= 1 && i <= 4) begin
        wren = 1'b1; wmask = 2'b11; waddr = 4'd1; wdata = 32'hFFFF_FFFF;
        rden = 1'b1; raddr = {4'd1, 4'd1};
      end else begin
        wren = 1'b0; rden = 1'b0; wmask = '0;
      end
    end
  endtask

  int n;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_init_busy", 64'(init_busy), 64'd1);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    count_busy(n, 1'b1);
    chk("init_busy_cycles", 64'(n), 64'd16);

    step();
    rd(4'd0, 4'd15, 32'h0, 32'h0);              step();
    rd(4'd1, 4'd1, 32'h0, 32'h0);               step();

    wr(4'd5, 32'hDEAD_BEEF, 2'b11);             step();
    rd(4'd5, 4'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF); step();

    wr(4'd3, 32'h1111_2222, 2'b11);             step();
    wr(4'd3, 32'hAAAA_BBBB, 2'b10);             step();
    rd(4'd3, 4'd3, 32'hAAAA_2222, 32'hAAAA_2222); step();

    wr(4'd7, 32'hCAFE_0000, 2'b11);             step();
    wr(4'd7, 32'h1234_5678, 2'b01);
    rd(4'd7, 4'd5, 32'hCAFE_5678, 32'hDEAD_BEEF); step();

    wr(4'd5, 32'h0, 2'b00);                     step();
    rd(4'd5, 4'd3, 32'hDEAD_BEEF, 32'hAAAA_2222); step();
    rd(4'd3, 4'd7, 32'hAAAA_2222, 32'hCAFE_5678); step();
    rd(4'd7, 4'd7, 32'hCAFE_5678, 32'hCAFE_5678); step();

    wr(4'd3, 32'h5555_0000, 2'b10);
    rd(4'd3, 4'd0, 32'h5555_2222, 32'h0);       step();
    wr(4'd0, 32'hCCCC_DDDD, 2'b11);
    rd(4'd0, 4'd0, 32'hCCCC_DDDD, 32'hCCCC_DDDD); step();
    repeat (4) step();
    chk("queue_drain_1", 64'(sb.size()), 64'd0);

    // Read in flight when rst hits: it must never produce rvalid.
    rden = 1'b1; raddr = {4'd5, 4'd7};
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("sweep_busy", 64'(init_busy), 64'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    count_busy(n, 1'b0);
    chk("restart_busy_cycles", 64'(n), 64'd16);

    step();
    rd(4'd5, 4'd3, 32'h0, 32'h0);               step();
    rd(4'd7, 4'd0, 32'h0, 32'h0);               step();
    repeat (4) step();
    chk("queue_drain_2", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
